mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-to-writeback pipeline stage of the RV32 core. Captures the MEM-stage result (ALU result, data-memory read word, PC+4) into the MEM/WB register, formats load data by `funct3` and byte offset, and drives the register-file write port and the WB→EX forwarding path. Also handles stall/flush of the MEM/WB register, flags misaligned loads, and keeps a 64-bit retired-instruction counter.

## Interface
- No parameters (XLEN fixed at 32).
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `resetn` in 1: reset is synchronous and active-low.
- `memValid` in 1: MEM stage holds a real instruction (0 = bubble).
- `memRd` in 5: destination register.
- `memRegWrite` in 1: instruction writes `rd`.
- `memWbSel` in 2: 00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as 00).
- `memFunct3` in 3: load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `aluResult` in 32: ALU result / effective address.
- `readData` in 32: word from data memory, word-aligned, valid in the same cycle as `aluResult`.
- `pcPlus4` in 32: return address for JAL/JALR.
- `stall` in 1: hold MEM/WB register contents.
- `flush` in 1: load a bubble into MEM/WB.
- `rfWriteEnable` out 1: register-file write strobe.
- `rfWriteAddr` out 5: register-file write address.
- `rfWriteData` out 32: register-file write data.
- `fwdValid` out 1: forwarding entry valid (equals `rfWriteEnable`).
- `fwdRd` out 5 / `fwdData` out 32: forwarding address/data (equal `rfWriteAddr`/`rfWriteData`).
- `loadMisaligned` out 1: WB entry is a misaligned load (exception request to control).
- `instret` out 64: count of retired instructions.

## Operation
- MEM/WB register fields: `wbValid`, `wbRd`, `wbRegWrite`, `wbData[31:0]`, `wbMisaligned`.
- Update priority each edge: `!resetn` > `flush` > `stall` > advance.
- Reset: all fields 0, `instret` = 0.
- Flush: `wbValid`=0, `wbRegWrite`=0, `wbMisaligned`=0; others don't-care (drive 0).
- Stall: all fields hold; `instret` holds.
- Advance: capture `memValid`, `memRd`, `memRegWrite`, `wbData` = selected/formatted data, `wbMisaligned` = `memValid & (memWbSel==01) & misalign`.
- Load formatting (offset `a = aluResult[1:0]`): byte = `readData[8a+7:8a]`; half = `readData[16*a[1]+15:16*a[1]]`; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word; reserved `funct3` gives 0.
- Misalign: LH/LHU with `a[0]`=1; LW with `a`≠0. Byte loads never misalign.
- Outputs: `rfWriteEnable` = `wbValid & wbRegWrite & (wbRd≠0) & !wbMisaligned`; `rfWriteAddr` = `wbRd`; `rfWriteData` = `wbData`; `loadMisaligned` = `wbValid & wbMisaligned`.
- `instret` increments by 1 on each advancing edge that captures `memValid`=1 with no misalign; it never increments on stall, flush or bubble, and wraps at 2^64−1 → 0.

## Timing
- One-cycle latency: MEM inputs at edge N appear on WB outputs after edge N.
- All outputs are registered or derived combinationally from registered state only; there is no combinational path from inputs to outputs.
- Stall held for k cycles: outputs are constant for k cycles and `rfWriteEnable` stays asserted if it was set (re-writing the same value is permitted).
- `flush` and `stall` both high: flush wins.
- Reset mid-stream: the outputs after the reset edge are all 0 regardless of `stall`/`flush`.
- `instret` reflects a capture on the same edge as the WB register update.

## Test plan
- Reset: hold `resetn`=0 for 2 edges with `memValid`=1 → all outputs 0, `instret`=0.
- ALU op: `memRd`=5, `memWbSel`=00, `aluResult`=0x1234_5678 → next cycle `rfWriteEnable`=1, addr 5, data 0x1234_5678, `instret`=1.
- Loads with `readData`=0x80FF_7F01: LB at `a`=3 → 0xFFFF_FF80; LBU at `a`=3 → 0x0000_0080; LH at `a`=2 → 0xFFFF_80FF; LHU at `a`=0 → 0x0000_7F01; LW at `a`=0 → 0x80FF_7F01.
- Misalign: LW at `aluResult`=0x102 → `loadMisaligned`=1, `rfWriteEnable`=0, `instret` unchanged.
- x0 and JAL: write to `rd`=0 → `rfWriteEnable`=0 but `instret` increments; `memWbSel`=10 with `pcPlus4`=0x44 → data 0x44.
- Stall/flush: stall 3 cycles → outputs held and `instret` +0; stall+flush together → bubble, `rfWriteEnable`=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32 MEM/WB pipeline register with load formatting and retire counter
//
// Captures the MEM-stage result into the MEM/WB register, formats load data
// by funct3 and byte offset, and drives the register-file write port and the
// WB->EX forwarding path from that registered state.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   memValid, memRd,       MEM-stage instruction valid, destination register,
//   memRegWrite, memWbSel  write enable, writeback source select
//   memFunct3              load type
//   aluResult, readData,   ALU result / address, aligned memory word,
//   pcPlus4                return address
//   stall, flush           hold / bubble the MEM/WB register
//   rfWriteEnable/Addr/Data register-file write port
//   fwdValid/fwdRd/fwdData forwarding path (mirrors the write port)
//   loadMisaligned         WB entry is a misaligned load
//   instret                64-bit retired-instruction count

module mem_wb_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memValid,
    input  logic [4:0]  memRd,
    input  logic        memRegWrite,
    input  logic [1:0]  memWbSel,
    input  logic [2:0]  memFunct3,
    input  logic [31:0] aluResult,
    input  logic [31:0] readData,
    input  logic [31:0] pcPlus4,
    input  logic        stall,
    input  logic        flush,
    output logic        rfWriteEnable,
    output logic [4:0]  rfWriteAddr,
    output logic [31:0] rfWriteData,
    output logic        fwdValid,
    output logic [4:0]  fwdRd,
    output logic [31:0] fwdData,
    output logic        loadMisaligned,
    output logic [63:0] instret
);

    logic        wbValid;
    logic [4:0]  wbRd;
    logic        wbRegWrite;
    logic [31:0] wbData;
    logic        wbMisaligned;
    logic [63:0] instretCount;

    logic [1:0]  byteOffset;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadData;
    logic        misalign;
    logic [31:0] selData;
    logic        nextMisaligned;

    assign byteOffset = aluResult[1:0];

    always_comb begin
        byteVal = readData[7:0];
        case (byteOffset)
            2'd0: byteVal = readData[7:0];
            2'd1: byteVal = readData[15:8];
            2'd2: byteVal = readData[23:16];
            2'd3: byteVal = readData[31:24];
            default: byteVal = readData[7:0];
        endcase
    end

    // Halfword lane is chosen by a[1] only; a[0] is a misalign, not a shift.
    assign halfVal = byteOffset[1] ? readData[31:16] : readData[15:0];

    always_comb begin
        loadData = 32'd0;
        misalign = 1'b0;
        case (memFunct3)
            3'b000: loadData = {{24{byteVal[7]}}, byteVal};
            3'b001: begin
                loadData = {{16{halfVal[15]}}, halfVal};
                misalign = byteOffset[0];
            end
            3'b010: begin
                loadData = readData;
                misalign = (byteOffset != 2'd0);
            end
            3'b100: loadData = {24'd0, byteVal};
            3'b101: begin
                loadData = {16'd0, halfVal};
                misalign = byteOffset[0];
            end
            default: loadData = 32'd0;
        endcase
    end

    // Reserved select 11 falls back to the ALU result.
    always_comb begin
        selData = aluResult;
        case (memWbSel)
            2'b01:   selData = loadData;
            2'b10:   selData = pcPlus4;
            default: selData = aluResult;
        endcase
    end

    assign nextMisaligned = memValid & (memWbSel == 2'b01) & misalign;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wbValid      <= 1'b0;
            wbRd         <= 5'd0;
            wbRegWrite   <= 1'b0;
            wbData       <= 32'd0;
            wbMisaligned <= 1'b0;
            instretCount <= 64'd0;
        end else if (flush) begin
            wbValid      <= 1'b0;
            wbRd         <= 5'd0;
            wbRegWrite   <= 1'b0;
            wbData       <= 32'd0;
            wbMisaligned <= 1'b0;
        end else if (!stall) begin
            wbValid      <= memValid;
            wbRd         <= memRd;
            wbRegWrite   <= memRegWrite;
            wbData       <= selData;
            wbMisaligned <= nextMisaligned;
            // A misaligned load traps instead of retiring; wraps naturally at 2^64.
            if (memValid && !nextMisaligned) begin
                instretCount <= instretCount + 64'd1;
            end
        end
    end

    assign rfWriteEnable  = wbValid & wbRegWrite & (wbRd != 5'd0) & ~wbMisaligned;
    assign rfWriteAddr    = wbRd;
    assign rfWriteData    = wbData;
    assign fwdValid       = rfWriteEnable;
    assign fwdRd          = wbRd;
    assign fwdData        = wbData;
    assign loadMisaligned = wbValid & wbMisaligned;
    assign instret        = instretCount;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        memValid;
    logic [4:0]  memRd;
    logic        memRegWrite;
    logic [1:0]  memWbSel;
    logic [2:0]  memFunct3;
    logic [31:0] aluResult;
    logic [31:0] readData;
    logic [31:0] pcPlus4;
    logic        stall;
    logic        flush;
    logic        rfWriteEnable;
    logic [4:0]  rfWriteAddr;
    logic [31:0] rfWriteData;
    logic        fwdValid;
    logic [4:0]  fwdRd;
    logic [31:0] fwdData;
    logic        loadMisaligned;
    logic [63:0] instret;

    mem_wb_stage dut (
        .clk(clk), .resetn(resetn), .memValid(memValid), .memRd(memRd),
        .memRegWrite(memRegWrite), .memWbSel(memWbSel), .memFunct3(memFunct3),
        .aluResult(aluResult), .readData(readData), .pcPlus4(pcPlus4),
        .stall(stall), .flush(flush), .rfWriteEnable(rfWriteEnable),
        .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData), .fwdValid(fwdValid),
        .fwdRd(fwdRd), .fwdData(fwdData), .loadMisaligned(loadMisaligned),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] expCnt;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [140:0] packExp(exp_t x);
        return {x.we, x.addr, x.data, x.we, x.addr, x.data, x.mis, x.cnt};
    endfunction

    function automatic logic [140:0] obsVec();
        return {rfWriteEnable, rfWriteAddr, rfWriteData, fwdValid, fwdRd, fwdData,
                loadMisaligned, instret};
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc, input logic st, input logic fl);
        memValid = v; memRd = rd; memRegWrite = rw; memWbSel = sel;
        memFunct3 = f3; aluResult = alu; readData = rdat; pcPlus4 = pc;
        stall = st; flush = fl;
    endtask

    task automatic push(input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic mis);
        exp_t x;
        x.we = we; x.addr = addr; x.data = data; x.mis = mis; x.cnt = expCnt;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = 64'd0;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 5'd0, 32'd0, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (obsVec() !== packExp(e)) begin
                errors++;
                $display("FAIL reset_%0d: got %h want %h", i, obsVec(), packExp(e));
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd5, 32'h1234_5678, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL alu_write: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  offs[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] want[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd10, 1'b1, 2'b01, f3s[i], 32'h0000_1000 | {30'd0, offs[i]},
                  32'h80FF_7F01, 32'h0, 1'b0, 1'b0);
            expCnt = expCnt + 1;
            push(1'b1, 5'd10, want[i], 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (obsVec() !== packExp(e)) begin
                errors++;
                $display("FAIL load_%0d: got %h want %h", i, obsVec(), packExp(e));
            end
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 5'd11, 1'b1, 2'b01, 3'b010, 32'h0000_0102, 32'hA5A5_5A5A,
              32'h0, 1'b0, 1'b0);
        push(1'b0, 5'd11, 32'hA5A5_5A5A, 1'b1);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL misalign_lw: got %h want %h", obsVec(), packExp(e));
        end
        drive(1'b1, 5'd12, 1'b1, 2'b01, 3'b101, 32'h0000_0201, 32'h1122_3344,
              32'h0, 1'b0, 1'b0);
        push(1'b0, 5'd12, 32'h0000_3344, 1'b1);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL misalign_lhu: got %h want %h", obsVec(), packExp(e));
        end
        // Misalign-shaped offset on a non-load select is not a trap.
        drive(1'b1, 5'd13, 1'b1, 2'b00, 3'b010, 32'h0000_0103, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd13, 32'h0000_0103, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL misalign_alu: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_x0_jal();
        drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'h0000_0777, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b0, 5'd0, 32'h0000_0777, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL x0_write: got %h want %h", obsVec(), packExp(e));
        end
        drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_0044,
              1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd1, 32'h0000_0044, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL jal_link: got %h want %h", obsVec(), packExp(e));
        end
        drive(1'b1, 5'd2, 1'b1, 2'b11, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0000_0044,
              1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd2, 32'h0000_0ABC, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL sel_reserved: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 5'd14, 1'b1, 2'b00, 3'b000, 32'h0000_5555, 32'h0, 32'h0, 1'b0, 1'b0);
        push(1'b0, 5'd14, 32'h0000_5555, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL bubble: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 5'd7, 1'b1, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd7, 32'hCAFE_0001, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL stall_setup: got %h want %h", obsVec(), packExp(e));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd20 + 5'(i), 1'b1, 2'b00, 3'b000, 32'hBAD0_0000 + i, 32'h0,
                  32'h0, 1'b1, 1'b0);
            push(1'b1, 5'd7, 32'hCAFE_0001, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (obsVec() !== packExp(e)) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obsVec(), packExp(e));
            end
        end
        drive(1'b1, 5'd8, 1'b1, 2'b00, 3'b000, 32'hCAFE_0002, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd8, 32'hCAFE_0002, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 5'd15, 1'b1, 2'b00, 3'b000, 32'h0000_F00D, 32'h0, 32'h0, 1'b1, 1'b1);
        push(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL flush_stall: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd16 + 5'(i), 1'b1, 2'b00, 3'b000, 32'h0BAD_F000 + 32'(i * 17),
                  32'h0, 32'h0, 1'b0, 1'b0);
            expCnt = expCnt + 1;
            push(1'b1, 5'd16 + 5'(i), 32'h0BAD_F000 + 32'(i * 17), 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if (obsVec() !== packExp(e)) begin
                errors++;
                $display("FAIL b2b_%0d: got %h want %h", i, obsVec(), packExp(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        resetn = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'h1111_2222, 32'h0, 32'h0, 1'b1, 1'b1);
        expCnt = 64'd0;
        push(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", obsVec(), packExp(e));
        end
        resetn = 1'b1;
        drive(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h3333_4444, 32'h0, 32'h0, 1'b0, 1'b0);
        expCnt = expCnt + 1;
        push(1'b1, 5'd4, 32'h3333_4444, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if (obsVec() !== packExp(e)) begin
            errors++;
            $display("FAIL after_reset: got %h want %h", obsVec(), packExp(e));
        end
    endtask

    initial begin
        resetn = 1'b0;
        expCnt = 64'd0;
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_alu();
        test_loads();
        test_misalign();
        test_x0_jal();
        test_bubble();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
